// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core
//   Multi-cycle core for a word-addressed MIPS-like ISA. The FSM walks
//   START -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and shares one memory
//   port for instruction fetch and data access. The port uses a req/ready
//   handshake, so the memory may insert any number of wait states. The
//   register file, ALU and immediate extension are all internal. The core
//   stops on HALT or on an undefined opcode/funct.
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   mem_req, mem_we       access request; 1 = store, 0 = load/fetch
//   mem_addr, mem_wdata   word address, store data (rt)
//   mem_rdata, mem_ready  read data; a transfer happens on an edge where
//                         mem_req && mem_ready
//   pc, instr, alu_res    architectural/debug visibility
//   halted, illegal       core stopped; illegal = stopped on an undefined opcode
module multicycle_cpu_core #(
    parameter int                ADDR_W   = 32,
    parameter int                NREGS    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic [31:0]       alu_res,
    output logic              halted,
    output logic              illegal
);
    localparam int RIDX_W = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ST_START, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [31:0]       instr_reg, a_reg, b_reg, imm_reg, alu_res_reg, mdr_reg;
    logic              halted_reg, illegal_reg;

    logic [5:0]        op, funct;
    logic [4:0]        shamt;
    logic [RIDX_W-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
    logic [31:0]       alu_next, wb_data;
    logic              xfer, wb_en, op_ok, br_taken;
    logic [ADDR_W-1:0] pc_plus1, br_target, j_target;
    logic [NREGS-1:0][31:0] rf_q;

    assign op     = instr_reg[31:26];
    assign funct  = instr_reg[5:0];
    assign shamt  = instr_reg[10:6];
    assign rs_idx = instr_reg[21 +: RIDX_W];
    assign rt_idx = instr_reg[16 +: RIDX_W];
    assign rd_idx = instr_reg[11 +: RIDX_W];

    // mem_req is decoded from state only, so mem_ready outside a request is ignored.
    assign xfer = mem_req && mem_ready;

    always_comb begin
        op_ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL: op_ok = 1'b1;
                    default: op_ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    // Default ALU op is A + imm: addi and the lw/sw effective address.
    always_comb begin
        alu_next = a_reg + imm_reg;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_next = a_reg + b_reg;
                FN_SUB:  alu_next = a_reg - b_reg;
                FN_AND:  alu_next = a_reg & b_reg;
                FN_OR:   alu_next = a_reg | b_reg;
                FN_SLT:  alu_next = {31'b0, $signed(a_reg) < $signed(b_reg)};
                FN_SLL:  alu_next = b_reg << shamt;
                default: alu_next = a_reg + b_reg;
            endcase
        end else if (op == OP_ORI) begin
            alu_next = a_reg | imm_reg;
        end else if (op == OP_BEQ || op == OP_BNE) begin
            alu_next = a_reg - b_reg;
        end
    end

    assign br_taken  = (op == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);
    assign pc_plus1  = pc_reg + ADDR_W'(1);
    assign br_target = pc_plus1 + imm_reg[ADDR_W-1:0];

    // Jump keeps the PC bits above the 26-bit target field when they exist.
    if (ADDR_W > 26) begin : g_jwide
        assign j_target = {pc_reg[ADDR_W-1:26], instr_reg[25:0]};
    end else begin : g_jnarrow
        assign j_target = instr_reg[ADDR_W-1:0];
    end

    assign wb_en   = (state_reg == ST_WB);
    assign wb_idx  = (op == OP_RTYPE) ? rd_idx : rt_idx;
    assign wb_data = (op == OP_LW) ? mdr_reg : alu_res_reg;

    // Register file: r0 is hard-wired to zero, so writes to it simply vanish.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
        if (gi == 0) begin : g_zero
            assign rf_q[gi] = '0;
        end else begin : g_reg
            logic [31:0] q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (wb_en && wb_idx == RIDX_W'(gi)) begin
                    q_reg <= wb_data;
                end
            end
            assign rf_q[gi] = q_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_START;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            ST_START:  state_next = ST_FETCH;
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_reg;
                if (mem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: state_next = op_ok ? ST_EXEC : ST_HALT;
            ST_EXEC: begin
                case (op)
                    OP_RTYPE, OP_ADDI, OP_ORI: state_next = ST_WB;
                    OP_LW, OP_SW:              state_next = ST_MEM;
                    OP_BEQ, OP_BNE, OP_J:      state_next = ST_FETCH;
                    default:                   state_next = ST_HALT;
                endcase
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (op == OP_SW);
                mem_addr  = alu_res_reg[ADDR_W-1:0];
                mem_wdata = b_reg;
                if (mem_ready) state_next = (op == OP_SW) ? ST_FETCH : ST_WB;
            end
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg      <= RESET_PC;
            instr_reg   <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            imm_reg     <= '0;
            alu_res_reg <= '0;
            mdr_reg     <= '0;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: if (xfer) instr_reg <= mem_rdata;
                ST_DECODE: begin
                    a_reg   <= rf_q[rs_idx];
                    b_reg   <= rf_q[rt_idx];
                    imm_reg <= (op == OP_ORI) ? {16'b0, instr_reg[15:0]}
                                              : {{16{instr_reg[15]}}, instr_reg[15:0]};
                    if (!op_ok) begin
                        halted_reg  <= 1'b1;
                        illegal_reg <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    alu_res_reg <= alu_next;
                    case (op)
                        OP_BEQ, OP_BNE: pc_reg <= br_taken ? br_target : pc_plus1;
                        OP_J:           pc_reg <= j_target;
                        OP_HALT:        halted_reg <= 1'b1;
                        default:        ;
                    endcase
                end
                ST_MEM: begin
                    if (xfer) begin
                        if (op == OP_SW) pc_reg <= pc_plus1;
                        else             mdr_reg <= mem_rdata;
                    end
                end
                ST_WB:   pc_reg <= pc_plus1;
                default: ;
            endcase
        end
    end

    assign pc      = pc_reg;
    assign instr   = instr_reg;
    assign alu_res = alu_res_reg;
    assign halted  = halted_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed testbench for multicycle_cpu_core: a 256-word memory model with
// programmable wait states, hand-encoded programs and hand-computed results.
module tb_multicycle_cpu_core;
    logic        clk;
    logic        rst_n;
    logic        mem_req, mem_we, mem_ready, halted, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instr, alu_res;

    logic        m16_req, m16_we, m16_halted, m16_illegal;
    logic [15:0] m16_addr, m16_pc;
    logic [31:0] m16_wdata, m16_rdata, m16_instr, m16_alu_res;

    logic [31:0] mem [256];
    int          wait_cfg;
    int          wait_cnt;
    int          cyc;
    int          chk_cnt;
    int          pass_cnt;
    int          we_cycles;
    int          req_after_halt;
    logic [31:0] we_addr_last;
    int          snap_we;
    int          snap_req;

    multicycle_cpu_core dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .instr(instr), .alu_res(alu_res),
        .halted(halted), .illegal(illegal)
    );

    // Narrow-address instance: reads the same memory, never writes it.
    multicycle_cpu_core #(.ADDR_W(16), .NREGS(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .mem_req(m16_req), .mem_we(m16_we), .mem_addr(m16_addr),
        .mem_wdata(m16_wdata), .mem_rdata(m16_rdata), .mem_ready(1'b1),
        .pc(m16_pc), .instr(m16_instr), .alu_res(m16_alu_res),
        .halted(m16_halted), .illegal(m16_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];
    assign m16_rdata = mem[m16_addr[7:0]];
    assign mem_ready = (wait_cnt >= wait_cfg);

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    wait_cnt <= 0;
        else if (mem_req && mem_ready) wait_cnt <= 0;
        else if (mem_req)              wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    initial begin
        we_cycles      = 0;
        req_after_halt = 0;
        we_addr_last   = '0;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            we_cycles    <= we_cycles + 1;
            we_addr_last <= mem_addr;
        end
        if (halted && mem_req) req_after_halt <= req_after_halt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic begin_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_to_halt(input int limit);
        while (!halted && cyc < limit) tick();
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        cyc      = 0;
        wait_cfg = 0;
        rst_n    = 1'b0;

        // 1: reset state, addi + halt, zero-wait timing
        begin_reset();
        mem[0] = 32'h20010005;
        mem[1] = 32'hFC000000;
        check_val("rst_req", {31'b0, mem_req}, 32'h0);
        check_val("rst_we", {31'b0, mem_we}, 32'h0);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_alu", alu_res, 32'h0);
        check_val("rst_halted", {31'b0, halted}, 32'h0);
        check_val("rst_illegal", {31'b0, illegal}, 32'h0);
        release_reset();
        check_val("t1_start_req", {31'b0, mem_req}, 32'h0);
        tick();
        check_val("t1_first_req", {31'b0, mem_req}, 32'h1);
        check_val("t1_first_addr", mem_addr, 32'h0);
        tick(); tick(); tick();
        check_val("t1_addi_alu", alu_res, 32'h5);
        run_to_halt(100);
        check_val("t1_cycles", cyc, 8);
        check_val("t1_illegal", {31'b0, illegal}, 32'h0);
        check_val("t1_pc", pc, 32'h1);
        $display("t1 addi/halt: halted at cycle %0d pc=%0h", cyc, pc);

        // 2: three wait states per access
        begin_reset();
        mem[0] = 32'h20010005;
        mem[1] = 32'hFC000000;
        wait_cfg = 3;
        release_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_val($sformatf("t2_hold_req_%0d", k), {31'b0, mem_req}, 32'h1);
            check_val($sformatf("t2_hold_addr_%0d", k), mem_addr, 32'h0);
        end
        check_val("t2_instr_not_early", instr, 32'h0);
        run_to_halt(100);
        check_val("t2_cycles", cyc, 14);
        check_val("t2_illegal", {31'b0, illegal}, 32'h0);
        $display("t2 waits: halted at cycle %0d", cyc);
        wait_cfg = 0;

        // 3: lw then sw
        begin_reset();
        mem[0]    = 32'h8C020010;
        mem[1]    = 32'hAC020011;
        mem[2]    = 32'hFC000000;
        mem[8'h10] = 32'hDEADBEEF;
        snap_we = we_cycles;
        release_reset();
        run_to_halt(100);
        check_val("t3_cycles", cyc, 13);
        check_val("t3_store", mem[8'h11], 32'hDEADBEEF);
        check_val("t3_we_cycles", we_cycles - snap_we, 1);
        check_val("t3_we_addr", we_addr_last, 32'h11);
        $display("t3 lw/sw: mem[11]=%08h halted at cycle %0d", mem[8'h11], cyc);

        // 4a: beq taken to itself loops forever
        begin_reset();
        mem[0] = 32'h20010007;
        mem[1] = 32'h20020007;
        mem[2] = 32'h1022FFFF;
        release_reset();
        while (cyc < 12) tick();
        check_val("t4_beq_pc", pc, 32'h2);
        check_val("t4_beq_req_addr", mem_addr, 32'h2);
        while (cyc < 15) tick();
        check_val("t4_beq_pc_again", pc, 32'h2);
        check_val("t4_beq_not_halted", {31'b0, halted}, 32'h0);
        $display("t4a beq loop: pc=%0h at cycle %0d", pc, cyc);

        // 4b: bne not taken, bne taken over two illegal words
        begin_reset();
        mem[0] = 32'h20010007;
        mem[1] = 32'h20020007;
        mem[2] = 32'h1422FFFF;
        mem[3] = 32'h14200002;
        mem[4] = 32'h54000000;
        mem[5] = 32'h54000000;
        mem[6] = 32'hFC000000;
        release_reset();
        run_to_halt(100);
        check_val("t4_bne_cycles", cyc, 18);
        check_val("t4_bne_pc", pc, 32'h6);
        check_val("t4_bne_illegal", {31'b0, illegal}, 32'h0);
        $display("t4b bne: pc=%0h halted at cycle %0d", pc, cyc);

        // 4c: jump with all target bits set, 32- and 16-bit address
        begin_reset();
        mem[0]    = 32'h0BFFFFFF;
        mem[8'hFF] = 32'hFC000000;
        release_reset();
        run_to_halt(100);
        check_val("t4_j_cycles", cyc, 7);
        check_val("t4_j_pc32", pc, 32'h03FFFFFF);
        check_val("t4_j_pc16", {16'h0, m16_pc}, 32'h0000FFFF);
        check_val("t4_j16_halted", {31'b0, m16_halted}, 32'h1);
        $display("t4c j: pc32=%08h pc16=%04h", pc, m16_pc);

        // 5: r0 is immutable; illegal opcode stops the core
        begin_reset();
        mem[0]    = 32'h20000009;
        mem[1]    = 32'h00001820;
        mem[2]    = 32'hAC030020;
        mem[3]    = 32'h54000000;
        mem[8'h20] = 32'hFFFFFFFF;
        release_reset();
        run_to_halt(100);
        check_val("t5_cycles", cyc, 15);
        check_val("t5_r3_zero", mem[8'h20], 32'h0);
        check_val("t5_illegal", {31'b0, illegal}, 32'h1);
        check_val("t5_pc", pc, 32'h3);
        snap_req = req_after_halt;
        repeat (10) tick();
        check_val("t5_no_req_after_halt", req_after_halt - snap_req, 0);
        $display("t5 r0/illegal: halted=%0b illegal=%0b at cycle %0d", halted, illegal, cyc - 10);

        // 6: async reset while a fetch waits
        begin_reset();
        mem[0] = 32'h20010005;
        mem[1] = 32'hFC000000;
        wait_cfg = 3;
        release_reset();
        while (cyc < 9) tick();
        check_val("t6_wait_req", {31'b0, mem_req}, 32'h1);
        check_val("t6_wait_pc", pc, 32'h1);
        rst_n = 1'b0;
        #1;
        check_val("t6_req_drop", {31'b0, mem_req}, 32'h0);
        check_val("t6_pc_reset", pc, 32'h0);
        check_val("t6_instr_reset", instr, 32'h0);
        repeat (2) @(negedge clk);
        release_reset();
        check_val("t6_start_req", {31'b0, mem_req}, 32'h0);
        tick();
        check_val("t6_refetch_req", {31'b0, mem_req}, 32'h1);
        check_val("t6_refetch_addr", mem_addr, 32'h0);
        run_to_halt(100);
        check_val("t6_cycles", cyc, 14);
        $display("t6 reset mid-fetch: halted at cycle %0d", cyc);
        wait_cfg = 0;

        // 7: ALU operations, results stored to 0x30..0x34
        begin_reset();
        mem[0]  = 32'h2001FFFD;
        mem[1]  = 32'h34028005;
        mem[2]  = 32'h00221822;
        mem[3]  = 32'h0022202A;
        mem[4]  = 32'h00022900;
        mem[5]  = 32'h00223024;
        mem[6]  = 32'h00223825;
        mem[7]  = 32'hAC030030;
        mem[8]  = 32'hAC040031;
        mem[9]  = 32'hAC050032;
        mem[10] = 32'hAC060033;
        mem[11] = 32'hAC070034;
        mem[12] = 32'hFC000000;
        release_reset();
        run_to_halt(200);
        check_val("t7_cycles", cyc, 52);
        check_val("t7_sub", mem[8'h30], 32'hFFFF7FF8);
        check_val("t7_slt", mem[8'h31], 32'h00000001);
        check_val("t7_sll", mem[8'h32], 32'h00080050);
        check_val("t7_and", mem[8'h33], 32'h00008005);
        check_val("t7_or", mem[8'h34], 32'hFFFFFFFD);
        $display("t7 alu: sub=%08h slt=%08h sll=%08h and=%08h or=%08h",
                 mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33], mem[8'h34]);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
